// File: rtl/pkt_rx_fifo.sv
// pkt_rx_fifo: receive end of the valid-only packet bus.
// Each incoming beat (addr + data) is written into a DEPTH-entry FIFO and
// offered downstream on a show-ahead valid/ready stream. The source cannot be
// stalled, so a beat that arrives while the FIFO is full is dropped. Drops set
// a sticky flag and bump a saturating counter so software can see the loss.
module pkt_rx_fifo #(
    parameter int ADDR_WD = 7,
    parameter int DATA_WD = 32,
    parameter int DEPTH   = 8,
    parameter int CNT_WD  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    input  logic [ADDR_WD-1:0]       in_addr,
    input  logic [DATA_WD-1:0]       in_data,
    output logic                     out_vld,
    output logic [ADDR_WD-1:0]       out_addr,
    output logic [DATA_WD-1:0]       out_data,
    input  logic                     out_rdy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [CNT_WD-1:0]        drop_cnt,
    input  logic                     ovf_clr
);

    localparam int IDX_WD = $clog2(DEPTH);
    localparam int PTR_WD = IDX_WD + 1;
    localparam int ENT_WD = ADDR_WD + DATA_WD;

    // Storage and pointers. The pointer MSB is a wrap bit so that full and
    // empty can be told apart when the index bits are equal.
    logic [ENT_WD-1:0] mem_q [DEPTH];
    logic [PTR_WD-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WD-1:0] rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic [CNT_WD-1:0] drop_cnt_q, drop_cnt_d;

    logic              push;
    logic              pop;
    logic              drop;
    logic [ENT_WD-1:0] head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IDX_WD-1:0] == rd_ptr_q[IDX_WD-1:0]) &&
                   (wr_ptr_q[IDX_WD] != rd_ptr_q[IDX_WD]);
    assign level = wr_ptr_q - rd_ptr_q;

    // Full is the registered state from before the edge, so a pop in the
    // same cycle never makes room for a beat that arrives while full.
    assign push = in_vld && !full;
    assign drop = in_vld && full;
    assign pop  = out_vld && out_rdy;

    // Show-ahead head; forced to zero while empty so stale storage never
    // leaks onto the output bus.
    assign head     = empty ? '0 : mem_q[rd_ptr_q[IDX_WD-1:0]];
    assign out_vld  = !empty;
    assign out_addr = head[ENT_WD-1:DATA_WD];
    assign out_data = head[DATA_WD-1:0];
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

    // Next-state for pointers and the drop bookkeeping.
    // NOTE: every signal assigned here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_WD'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_WD'(1);

        if (drop) begin
            // A drop coinciding with a clear counts as the first new event.
            ovf_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = CNT_WD'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_WD'(1);
            end
        end else if (ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // Control state register; reset empties the FIFO immediately.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage write.
    // NOTE: the array is deliberately not reset; the pointers alone define
    // which entries are live, and unreset storage maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[IDX_WD-1:0]] <= {in_addr, in_data};
    end

endmodule

// File: tb/tb_pkt_rx_fifo.sv
// Self-checking bench for pkt_rx_fifo. Inputs are driven after the falling
// edge; a queue model is updated at each rising edge and every output is
// compared against it at the next falling edge. Directed checks with literal
// expectations cover the listed scenarios. The drop counter is built narrow
// so that saturation is reachable in a few cycles.
module tb_pkt_rx_fifo;

    localparam int AW      = 7;
    localparam int DW      = 32;
    localparam int DEPTH   = 8;
    localparam int CW      = 4;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef logic [AW+DW-1:0] ent_t;

    logic          clk;
    logic          rst_n;
    logic          in_vld;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          out_vld;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_rdy;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          ovf;
    logic [CW-1:0] drop_cnt;
    logic          ovf_clr;

    pkt_rx_fifo #(
        .ADDR_WD(AW), .DATA_WD(DW), .DEPTH(DEPTH), .CNT_WD(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_addr(in_addr), .in_data(in_data),
        .out_vld(out_vld), .out_addr(out_addr), .out_data(out_data), .out_rdy(out_rdy),
        .full(full), .empty(empty), .level(level),
        .ovf(ovf), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expected FIFO contents plus drop bookkeeping.
    ent_t sb[$];
    bit   m_ovf;
    int   m_cnt;
    int   checks;
    int   failures;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        ent_t h;
        h = (sb.size() > 0) ? sb[0] : '0;
        check("out_vld",  64'(out_vld),  64'(sb.size() > 0));
        check("empty",    64'(empty),    64'(sb.size() == 0));
        check("full",     64'(full),     64'(sb.size() == DEPTH));
        check("level",    64'(level),    64'(sb.size()));
        check("ovf",      64'(ovf),      64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
        check("out_addr", 64'(out_addr), 64'(h[AW+DW-1:DW]));
        check("out_data", 64'(out_data), 64'(h[DW-1:0]));
    endtask

    // One clock cycle: drive, predict at the rising edge, compare afterwards.
    task automatic step(input logic vld, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic rdy, input logic clr);
        bit push, pop, drop;
        in_vld = vld; in_addr = a; in_data = d; out_rdy = rdy; ovf_clr = clr;
        drop = vld && (sb.size() == DEPTH);
        push = vld && !drop;
        pop  = rdy && (sb.size() > 0);
        @(posedge clk);
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back({a, d});
        if (drop) begin
            m_ovf = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        @(negedge clk);
        in_vld = 1'b0; in_addr = '0; in_data = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
        check_outputs();
    endtask

    task automatic fill_0_to_7();
        for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), DW'(i), 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0; failures = 0; m_ovf = 1'b0; m_cnt = 0;
        rst_n = 1'b0; in_vld = 1'b0; in_addr = '0; in_data = '0;
        out_rdy = 1'b0; ovf_clr = 1'b0;
        @(negedge clk); @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // 2: single beat, one-cycle latency, no combinational in->out path.
        in_vld = 1'b1; in_addr = 7'h15; in_data = 32'hDEAD_BEEF;
        #1 check("t2_no_comb_path", 64'(out_vld), 64'(0));
        step(1'b1, 7'h15, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check("t2_vld",  64'(out_vld),  64'(1));
        check("t2_addr", 64'(out_addr), 64'(7'h15));
        check("t2_data", 64'(out_data), 64'(32'hDEAD_BEEF));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("t2_empty_after", 64'(empty), 64'(1));

        // 3: fill with rdy low, then drain in order.
        fill_0_to_7();
        check("t3_full",  64'(full),  64'(1));
        check("t3_level", 64'(level), 64'(8));
        for (int i = 0; i < DEPTH; i++) begin
            check("t3_order", 64'(out_data), 64'(i));
            step(1'b0, '0, '0, 1'b1, 1'b0);
        end
        check("t3_empty", 64'(empty), 64'(1));

        // 4: overflow, clear, drop coincident with clear.
        fill_0_to_7();
        for (int k = 0; k < 3; k++) step(1'b1, 7'h7F, 32'hBAD0 + DW'(k), 1'b0, 1'b0);
        check("t4_drop_cnt3", 64'(drop_cnt), 64'(3));
        check("t4_ovf_set",   64'(ovf),      64'(1));
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check("t4_clr_ovf", 64'(ovf),      64'(0));
        check("t4_clr_cnt", 64'(drop_cnt), 64'(0));
        step(1'b1, 7'h7E, 32'hBAD9, 1'b0, 1'b1);
        check("t4_clr_drop_cnt", 64'(drop_cnt), 64'(1));
        check("t4_clr_drop_ovf", 64'(ovf),      64'(1));

        // 6: full + push + pop: head leaves, new beat is dropped.
        check("t6_head_before", 64'(out_data), 64'(0));
        step(1'b1, 7'h11, 32'h99, 1'b1, 1'b0);
        check("t6_level",    64'(level),    64'(7));
        check("t6_drop_cnt", 64'(drop_cnt), 64'(2));
        for (int i = 1; i < DEPTH; i++) begin
            check("t4_stored", 64'(out_data), 64'(i));
            step(1'b0, '0, '0, 1'b1, 1'b0);
        end
        check("t4_empty", 64'(empty), 64'(1));

        // Saturation of the drop counter.
        fill_0_to_7();
        for (int k = 0; k < 20; k++) step(1'b1, '0, 32'h5A5A, 1'b0, 1'b0);
        check("sat_cnt", 64'(drop_cnt), 64'(CNT_MAX));
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // 5: continuous streaming across several pointer wraps.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, AW'(i), 32'h1000 + DW'(i), 1'b1, 1'b0);
            check("t5_level_le1", 64'(level <= 1), 64'(1));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("t5_drop_cnt", 64'(drop_cnt), 64'(0));
        check("t5_empty",    64'(empty),    64'(1));

        // 1: reset mid-traffic clears everything without a clock edge.
        fill_0_to_7();
        in_vld = 1'b1; in_addr = 7'h33; in_data = 32'h3333;
        step(1'b1, 7'h33, 32'h3333, 1'b0, 1'b0);
        in_vld = 1'b1; out_rdy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t1_vld",   64'(out_vld),  64'(0));
        check("t1_empty", 64'(empty),    64'(1));
        check("t1_level", 64'(level),    64'(0));
        check("t1_ovf",   64'(ovf),      64'(0));
        check("t1_cnt",   64'(drop_cnt), 64'(0));
        sb.delete(); m_ovf = 1'b0; m_cnt = 0;
        @(negedge clk);
        in_vld = 1'b0;
        rst_n = 1'b1;
        check_outputs();
        step(1'b1, 7'h2A, 32'hCAFE_F00D, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
